// File: rtl/seg_scan_receiver_pkg.sv
// Shared definitions for the segment-scan receiver.
//   - 7-bit segment pattern constants {g,f,e,d,c,b,a}, active-high
//   - scan FSM state encoding
//   - digit index width and one-hot strobe to slot index helper
package seg_scan_receiver_pkg;

    localparam int DIGIT_IDX_W = 2;

    typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // Only called with a one-hot strobe; anything else maps to slot 0.
    function automatic digit_idx_t sel_to_idx(input logic [3:0] sel);
        digit_idx_t idx;
        case (sel)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_receiver_decode.sv
// seg7_decode: combinational 7-segment pattern to BCD decoder.
//   seg_i   [6:0] pattern {g,f,e,d,c,b,a}, active-high
//   valid_o       pattern is a known digit or blank
//   blank_o       pattern is all-off
//   bcd_o   [3:0] decoded digit; 0 for blank and for unknown patterns
module seg7_decode
    import seg_scan_receiver_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic       blank_o,
    output logic [3:0] bcd_o
);

    always_comb begin
        valid_o = 1'b1;
        blank_o = 1'b0;
        bcd_o   = 4'd0;
        case (seg_i)
            SEG_0:     bcd_o = 4'd0;
            SEG_1:     bcd_o = 4'd1;
            SEG_2:     bcd_o = 4'd2;
            SEG_3:     bcd_o = 4'd3;
            SEG_4:     bcd_o = 4'd4;
            SEG_5:     bcd_o = 4'd5;
            SEG_6:     bcd_o = 4'd6;
            SEG_7:     bcd_o = 4'd7;
            SEG_8:     bcd_o = 4'd8;
            SEG_9:     bcd_o = 4'd9;
            SEG_BLANK: blank_o = 1'b1;
            default:   valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_receiver.sv
// seg_scan_receiver: rebuilds the four digits shown by a multiplexed
// 7-segment scan and publishes them once the same frame was seen for
// STABLE_FRAMES consecutive complete scans.
//   clock, reset             system clock, async active-high reset
//   segment_in [6:0]         segment lines {g,f,e,d,c,b,a} (asynchronous)
//   byte_sel_in [3:0]        one-hot digit strobe, bit0 = rightmost digit
//   colon_in                 colon line
//   digits_out [15:0]        {d3,d2,d1,d0} BCD
//   blank_out [3:0]          per-digit blank flag
//   colon_out                colon of the published frame
//   frame_valid, frame_err   one-cycle pulses: published / discarded
//   stalled                  strobes frozen for TIMEOUT_CYCLES
//
// state  | meaning
// IDLE   | waiting for a legal one-hot strobe
// SETTLE | strobe held, counting settle cycles before capture
// HOLD   | slot captured, waiting for the strobe to move on
module seg_scan_receiver
    import seg_scan_receiver_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 3,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  segment_in,
    input  logic [3:0]  byte_sel_in,
    input  logic        colon_in,
    output logic [15:0] digits_out,
    output logic [3:0]  blank_out,
    output logic        colon_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stalled
);

    localparam logic [3:0] SETTLE_TC = 4'(SETTLE_CYCLES);
    localparam logic [2:0] STABLE_TC = 3'(STABLE_FRAMES);
    localparam logic [9:0] TMO_TC    = 10'(TIMEOUT_CYCLES);

    logic [6:0]  seg_s1_q, seg_s2_q;
    logic [3:0]  sel_s1_q, sel_s2_q, sel_prev_q;
    logic        col_s1_q, col_s2_q;

    logic [1:0]  state_q, state_d;
    logic [3:0]  settle_q, settle_d;
    logic [3:0]  cap_sel_q, cap_sel_d;

    logic [3:0]  seen_q, seen_d;
    logic [15:0] cand_dig_q, cand_dig_d;
    logic [3:0]  cand_blank_q, cand_blank_d;
    logic        cand_colon_q, cand_colon_d;
    logic        bad_q, bad_d;

    logic [15:0] ref_dig_q, ref_dig_d;
    logic [3:0]  ref_blank_q, ref_blank_d;
    logic        ref_colon_q, ref_colon_d;
    logic [2:0]  stable_q, stable_d;

    logic [15:0] dig_out_q, dig_out_d;
    logic [3:0]  blank_out_q, blank_out_d;
    logic        colon_out_q, colon_out_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        stalled_q, stalled_d;
    logic [9:0]  tmo_q, tmo_d;

    logic        dec_valid, dec_blank;
    logic [3:0]  dec_bcd;
    logic        sel_change, tmo_hit, complete, capture;
    digit_idx_t  slot;

    seg7_decode u_decode (
        .seg_i   (seg_s2_q),
        .valid_o (dec_valid),
        .blank_o (dec_blank),
        .bcd_o   (dec_bcd)
    );

    assign sel_change = (sel_s2_q != sel_prev_q);
    assign tmo_hit    = (tmo_q == TMO_TC);
    assign complete   = (seen_q == 4'hF);
    assign slot       = sel_to_idx(cap_sel_q);

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        cap_sel_d    = cap_sel_q;
        seen_d       = seen_q;
        cand_dig_d   = cand_dig_q;
        cand_blank_d = cand_blank_q;
        cand_colon_d = cand_colon_q;
        bad_d        = bad_q;
        ref_dig_d    = ref_dig_q;
        ref_blank_d  = ref_blank_q;
        ref_colon_d  = ref_colon_q;
        stable_d     = stable_q;
        dig_out_d    = dig_out_q;
        blank_out_d  = blank_out_q;
        colon_out_d  = colon_out_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        capture      = 1'b0;

        // Timeout counter and stalled level
        if (sel_change) begin
            tmo_d     = 10'd0;
            stalled_d = 1'b0;
        end else begin
            tmo_d     = (tmo_q == 10'h3FF) ? tmo_q : tmo_q + 10'd1;
            stalled_d = tmo_hit ? 1'b1 : stalled_q;
        end

        // Strobe FSM; cap_sel is always one-hot, so an illegal sel
        // also shows up as a mismatch against it.
        case (state_q)
            ST_IDLE: begin
                if ($onehot(sel_s2_q)) begin
                    state_d   = ST_SETTLE;
                    settle_d  = 4'd1;
                    cap_sel_d = sel_s2_q;
                end
            end
            ST_SETTLE: begin
                if (sel_s2_q != cap_sel_q) begin
                    state_d = ST_IDLE;
                end else if (settle_q == SETTLE_TC) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (sel_s2_q != cap_sel_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame completion; a timeout in the same cycle discards the
        // partial frame and suppresses any pulse.
        if (tmo_hit) begin
            seen_d       = 4'h0;
            stable_d     = 3'd0;
            cand_colon_d = 1'b0;
            bad_d        = 1'b0;
        end else if (complete) begin
            seen_d       = 4'h0;
            cand_colon_d = 1'b0;
            bad_d        = 1'b0;
            if (bad_q) begin
                err_d    = 1'b1;
                stable_d = 3'd0;
            end else begin
                if ({cand_dig_q, cand_blank_q, cand_colon_q} ==
                    {ref_dig_q, ref_blank_q, ref_colon_q}) begin
                    stable_d = (stable_q == STABLE_TC) ? stable_q : stable_q + 3'd1;
                end else begin
                    ref_dig_d   = cand_dig_q;
                    ref_blank_d = cand_blank_q;
                    ref_colon_d = cand_colon_q;
                    stable_d    = 3'd1;
                end
                if (stable_d == STABLE_TC && !stalled_q &&
                    {ref_dig_d, ref_blank_d, ref_colon_d} !=
                    {dig_out_q, blank_out_q, colon_out_q}) begin
                    dig_out_d   = ref_dig_d;
                    blank_out_d = ref_blank_d;
                    colon_out_d = ref_colon_d;
                    valid_d     = 1'b1;
                end
            end
        end

        // Slot capture is applied last so it survives a same-cycle clear.
        if (capture) begin
            seen_d[slot]                 = 1'b1;
            cand_dig_d[{slot, 2'b00} +: 4] = dec_bcd;
            cand_blank_d[slot]           = dec_blank;
            cand_colon_d                 = cand_colon_d | col_s2_q;
            if (!dec_valid) begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_s1_q     <= '0;
            seg_s2_q     <= '0;
            sel_s1_q     <= '0;
            sel_s2_q     <= '0;
            sel_prev_q   <= '0;
            col_s1_q     <= 1'b0;
            col_s2_q     <= 1'b0;
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            cap_sel_q    <= '0;
            seen_q       <= '0;
            cand_dig_q   <= '0;
            cand_blank_q <= '0;
            cand_colon_q <= 1'b0;
            bad_q        <= 1'b0;
            ref_dig_q    <= '0;
            ref_blank_q  <= '0;
            ref_colon_q  <= 1'b0;
            stable_q     <= '0;
            dig_out_q    <= '0;
            blank_out_q  <= '0;
            colon_out_q  <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            stalled_q    <= 1'b0;
            tmo_q        <= '0;
        end else begin
            seg_s1_q     <= segment_in;
            seg_s2_q     <= seg_s1_q;
            sel_s1_q     <= byte_sel_in;
            sel_s2_q     <= sel_s1_q;
            sel_prev_q   <= sel_s2_q;
            col_s1_q     <= colon_in;
            col_s2_q     <= col_s1_q;
            state_q      <= state_d;
            settle_q     <= settle_d;
            cap_sel_q    <= cap_sel_d;
            seen_q       <= seen_d;
            cand_dig_q   <= cand_dig_d;
            cand_blank_q <= cand_blank_d;
            cand_colon_q <= cand_colon_d;
            bad_q        <= bad_d;
            ref_dig_q    <= ref_dig_d;
            ref_blank_q  <= ref_blank_d;
            ref_colon_q  <= ref_colon_d;
            stable_q     <= stable_d;
            dig_out_q    <= dig_out_d;
            blank_out_q  <= blank_out_d;
            colon_out_q  <= colon_out_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            stalled_q    <= stalled_d;
            tmo_q        <= tmo_d;
        end
    end

    assign digits_out  = dig_out_q;
    assign blank_out   = blank_out_q;
    assign colon_out   = colon_out_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign stalled     = stalled_q;

endmodule

// File: tb/tb_seg_scan_receiver.sv
// Directed bench for seg_scan_receiver with default parameters
// (SETTLE_CYCLES=3, STABLE_FRAMES=2, TIMEOUT_CYCLES=1023).
module tb_seg_scan_receiver;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  segment_in = 7'h00;
    logic [3:0]  byte_sel_in = 4'h0;
    logic        colon_in = 1'b0;
    logic [15:0] digits_out;
    logic [3:0]  blank_out;
    logic        colon_out;
    logic        frame_valid;
    logic        frame_err;
    logic        stalled;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    seg_scan_receiver dut (
        .clock       (clock),
        .reset       (reset),
        .segment_in  (segment_in),
        .byte_sel_in (byte_sel_in),
        .colon_in    (colon_in),
        .digits_out  (digits_out),
        .blank_out   (blank_out),
        .colon_out   (colon_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .stalled     (stalled)
    );

    always #5 clock = ~clock;

    // Count pulse cycles; a stuck-high pulse inflates the count.
    always @(negedge clock) begin
        if (frame_valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1)   err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // One strobe window, driven at the falling edge.
    task automatic drive_digit(input logic [3:0] sel, input logic [6:0] pat,
                               input logic col, input int cycles);
        byte_sel_in = sel;
        segment_in  = pat;
        colon_in    = col;
        repeat (cycles) @(negedge clock);
    endtask

    // Full scan d3..d0, colon lit during the d2 and d1 windows.
    task automatic scan_frame(input logic [6:0] p3, input logic [6:0] p2,
                              input logic [6:0] p1, input logic [6:0] p0,
                              input logic c);
        drive_digit(4'b1000, p3, 1'b0, 8);
        drive_digit(4'b0100, p2, c, 8);
        drive_digit(4'b0010, p1, c, 8);
        drive_digit(4'b0001, p0, 1'b0, 8);
    endtask

    // Keep the last strobe held a few cycles so pulses land before checks.
    task automatic linger;
        repeat (3) @(negedge clock);
        #1;
    endtask

    initial begin
        int first_hi;

        // Reset
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_digits", 32'(digits_out), 32'h0);
        chk("rst_blank", 32'(blank_out), 32'h0);
        chk("rst_flags", {28'h0, colon_out, frame_valid, frame_err, stalled}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 12:34 scan
        scan_frame(seg(1), seg(2), seg(3), seg(4), 1'b1);
        linger();
        chk("f1_no_valid", 32'(valid_cnt), 32'd0);
        chk("f1_digits", 32'(digits_out), 32'h0);
        scan_frame(seg(1), seg(2), seg(3), seg(4), 1'b1);
        linger();
        chk("f2_valid", 32'(valid_cnt), 32'd1);
        chk("f2_digits", 32'(digits_out), 32'h1234);
        chk("f2_blank", 32'(blank_out), 32'h0);
        chk("f2_colon", 32'(colon_out), 32'h1);
        for (int i = 0; i < 3; i++) scan_frame(seg(1), seg(2), seg(3), seg(4), 1'b1);
        linger();
        chk("f5_no_repulse", 32'(valid_cnt), 32'd1);
        chk("f5_no_err", 32'(err_cnt), 32'd0);

        // Illegal pattern on d1, then 12:35
        scan_frame(seg(1), seg(2), 7'h49, seg(4), 1'b1);
        linger();
        chk("bad_err", 32'(err_cnt), 32'd1);
        chk("bad_hold", 32'(digits_out), 32'h1234);
        chk("bad_no_valid", 32'(valid_cnt), 32'd1);
        scan_frame(seg(1), seg(2), seg(3), seg(5), 1'b1);
        linger();
        chk("r1_no_valid", 32'(valid_cnt), 32'd1);
        scan_frame(seg(1), seg(2), seg(3), seg(5), 1'b1);
        linger();
        chk("r2_valid", 32'(valid_cnt), 32'd2);
        chk("r2_digits", 32'(digits_out), 32'h1235);

        // Month display: blank blank 0 7
        scan_frame(7'h00, 7'h00, seg(0), seg(7), 1'b0);
        scan_frame(7'h00, 7'h00, seg(0), seg(7), 1'b0);
        linger();
        chk("mon_valid", 32'(valid_cnt), 32'd3);
        chk("mon_digits", 32'(digits_out), 32'h0007);
        chk("mon_blank", 32'(blank_out), 32'hC);
        chk("mon_colon", 32'(colon_out), 32'h0);

        // Short strobe and two-hot strobe: d1 never captured
        drive_digit(4'b1000, seg(1), 1'b0, 8);
        drive_digit(4'b0100, seg(2), 1'b0, 8);
        drive_digit(4'b0010, seg(3), 1'b0, 2);
        drive_digit(4'b0011, seg(3), 1'b0, 8);
        drive_digit(4'b0001, seg(4), 1'b0, 8);
        linger();
        chk("glitch_no_valid", 32'(valid_cnt), 32'd3);
        chk("glitch_no_err", 32'(err_cnt), 32'd1);
        chk("glitch_hold", 32'(digits_out), 32'h0007);

        // Freeze at 0100: 2 sync + 1 detect + TIMEOUT + 1 register edges
        @(negedge clock);
        chk("pre_stall", 32'(stalled), 32'h0);
        byte_sel_in = 4'b0100;
        segment_in  = seg(2);
        first_hi = 0;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge clock);
            #1;
            if (stalled === 1'b1 && first_hi == 0) first_hi = n;
        end
        chk("stall_time", 32'(first_hi), 32'd1027);
        chk("stall_hold", 32'(digits_out), 32'h0007);
        @(negedge clock);
        scan_frame(seg(1), seg(2), seg(3), seg(6), 1'b1);
        linger();
        chk("resume_unstall", 32'(stalled), 32'h0);
        chk("resume_f1_no_valid", 32'(valid_cnt), 32'd3);
        scan_frame(seg(1), seg(2), seg(3), seg(6), 1'b1);
        linger();
        chk("resume_valid", 32'(valid_cnt), 32'd4);
        chk("resume_digits", 32'(digits_out), 32'h1236);

        // Reset while in SETTLE after a published frame
        @(negedge clock);
        byte_sel_in = 4'b1000;
        segment_in  = seg(1);
        colon_in    = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_digits", 32'(digits_out), 32'h0);
        chk("mid_rst_flags", {24'h0, blank_out, colon_out, frame_valid, frame_err, stalled}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        scan_frame(seg(1), seg(2), seg(3), seg(6), 1'b1);
        linger();
        chk("post_rst_f1", 32'(digits_out), 32'h0);
        chk("post_rst_f1_cnt", 32'(valid_cnt), 32'd4);
        scan_frame(seg(1), seg(2), seg(3), seg(6), 1'b1);
        linger();
        chk("post_rst_valid", 32'(valid_cnt), 32'd5);
        chk("post_rst_digits", 32'(digits_out), 32'h1236);
        chk("post_rst_colon", 32'(colon_out), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
